spi_mcu_master: RTL
===================

Name: spi_mcu_master

Overview:
MCU-side SPI master that drives the spi_mcu slave in the NDN router. Serialises one packet per start request: a header of {type bit, LENGTH_SZ-bit length, PREFIX_SZ-bit prefix}, then length payload bytes, all MSB first. It samples miso during the payload phase and returns the received bytes. It is used as the bench/board-side partner for spi_mcu and as the host interface model for the router.

Parameters:
CLK_DIV, 4, clk cycles per sclk half-period (legal range >= 2)
LENGTH_SZ, 6, width of the header length field (payload byte count)
PREFIX_SZ, 64, width of the header name prefix
CS_GAP, 4, clk cycles cs is held high after a frame before done/IDLE

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  request a frame; sampled only in IDLE
tx_type  in  1  header bit 0 (0 = interest, 1 = data)
tx_length  in  LENGTH_SZ  payload byte count, 0..2^LENGTH_SZ-1
tx_prefix  in  PREFIX_SZ  name prefix
tx_data  in  8  next payload byte
tx_data_valid  in  1  tx_data holds a valid byte
tx_data_ready  out  1  one-cycle pulse: tx_data consumed
sclk  out  1  SPI clock, mode 0, idles low
mosi  out  1  master out
miso  in  1  master in
cs  out  1  chip select, active-low
rx_byte  out  8  last received payload byte
rx_valid  out  1  one-cycle pulse: rx_byte updated
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset, and every output after any rst cycle: cs=1, sclk=0, mosi=0, busy=0, done=0, rx_valid=0, tx_data_ready=0, rx_byte=0, state=IDLE. Reset mid-frame aborts the frame with no done pulse.
- Accept: when start=1 in IDLE, latch tx_type, tx_length and tx_prefix into a HEADER_BITS=1+LENGTH_SZ+PREFIX_SZ (71) shift register. Next cycle: cs=0, busy=1, mosi=header MSB. start while busy is ignored.
- SPI mode 0: mosi changes only on sclk falling edges, or at cs assertion for the first bit. miso is sampled on sclk rising edges. The first rising edge occurs CLK_DIV cycles after cs falls. Each bit lasts 2*CLK_DIV cycles.
- States:
  - IDLE -> HEADER on start.
  - HEADER shifts 71 bits; miso is ignored. After the 71st rising edge, go to PAYLOAD if the latched length > 0, else HOLD.
  - PAYLOAD: at each byte boundary, on the falling edge, if tx_data_valid=1, load tx_data, pulse tx_data_ready for 1 cycle and drive its MSB. If tx_data_valid=0, stall: sclk held low, cs held low, no bit lost; resume CLK_DIV cycles after valid rises. After each 8th rising edge, set rx_byte to the byte shifted in MSB first and pulse rx_valid (1 cycle after that edge). After the last byte's 8th rising edge, go to HOLD.
  - HOLD: wait CLK_DIV cycles with sclk low, then cs=1 and mosi=0. After CS_GAP more cycles, pulse done, clear busy, return to IDLE.
- Total sclk rising edges per frame: exactly 71 + 8*length. sclk never glitches and never toggles while cs=1.
- Byte and bit counters are sized for the maximum length. Length 2^LENGTH_SZ-1 (63) must not wrap.

Decomposition:
- Package ndn_spi_pkg holds:
  - LENGTH_SZ, PREFIX_SZ and HEADER_BITS constants, shared with spi_mcu;
  - the state enum {IDLE, HEADER, PAYLOAD, HOLD};
  - TYPE_INTEREST = 0 and TYPE_DATA = 1.
- One sub-module: spi_sclk_gen. It is a divider counter that emits rise_stb and fall_stb strobes and holds sclk low while a hold/enable input is deasserted. The top module contains the FSM, shift registers and counters.

Test Plan:
- type=0, length=0, prefix=129, start pulse -> 71 rising edges; mosi bits 0, 000000, then 64-bit 129 MSB first; no tx_data_ready or rx_valid; done 1 cycle after cs rises plus CS_GAP; busy=0 afterwards.
- type=1, length=3, data "her" always valid -> 95 rising edges; payload bits 0x68, 0x65, 0x72 MSB first; exactly 3 tx_data_ready pulses.
- length=2 with miso driven 0xA5 then 0x3C -> rx_valid twice, with rx_byte=0xA5 then 0x3C; miso toggling during the header produces no rx_valid.
- length=2 with tx_data_valid low for 20 cycles before byte 2 -> sclk low and cs low throughout the stall; the byte is sent intact; edge count stays 87.
- rst asserted at header bit 30 -> next cycle cs=1, sclk=0, busy=0, no done; a following start sends a correct full frame.
- start asserted while busy and length=63 -> second start ignored; 575 rising edges; 63 tx_data_ready pulses; no counter wrap.

Source files
------------

// File: rtl/ndn_spi_pkg.sv
// Shared NDN SPI framing constants and state encoding, common to spi_mcu
// and its MCU-side master.
package ndn_spi_pkg;

  localparam int LENGTH_SZ   = 6;
  localparam int PREFIX_SZ   = 64;
  localparam int HEADER_BITS = 1 + LENGTH_SZ + PREFIX_SZ;

  localparam logic TYPE_INTEREST = 1'b0;
  localparam logic TYPE_DATA     = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    HOLD
  } spi_state_e;

endpackage

// File: rtl/spi_mcu_master_if.sv
// Host-side request/stream signals plus the SPI pins of the MCU master.
interface spi_mcu_master_if;
  import ndn_spi_pkg::*;

  logic                 start;
  logic                 tx_type;
  logic [LENGTH_SZ-1:0] tx_length;
  logic [PREFIX_SZ-1:0] tx_prefix;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;
  logic                 sclk;
  logic                 mosi;
  logic                 miso;
  logic                 cs;
  logic [7:0]           rx_byte;
  logic                 rx_valid;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, tx_type, tx_length, tx_prefix, tx_data, tx_data_valid, miso,
    output tx_data_ready, sclk, mosi, cs, rx_byte, rx_valid, busy, done
  );

  modport slave (
    output start, tx_type, tx_length, tx_prefix, tx_data, tx_data_valid, miso,
    input  tx_data_ready, sclk, mosi, cs, rx_byte, rx_valid, busy, done
  );

endinterface

// File: rtl/spi_sclk_gen.sv
// Mode-0 SPI clock divider: toggles sclk every CLK_DIV cycles while enabled,
// parks low with the phase counter cleared otherwise.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise_stb,
  output logic fall_stb
);
  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  assign wrap = en && (cnt_q == CNT_W'(CLK_DIV - 1));

  // Strobes lead the sclk register by one cycle, so the FSM acts on the
  // same edge at which sclk changes.
  assign rise_stb = wrap && !sclk_q;
  assign fall_stb = wrap &&  sclk_q;
  assign sclk     = sclk_q;

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/spi_mcu_master.sv
// MCU-side SPI master for the NDN router: sends {type, length, prefix} then
// length payload bytes MSB first, capturing miso bytes during the payload.
module spi_mcu_master
  import ndn_spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  spi_mcu_master_if.master bus
);
  localparam int BC_W = $clog2(HEADER_BITS);
  localparam int HC_W = $clog2(CLK_DIV + CS_GAP + 1);

  spi_state_e             state_q, state_d;
  logic [HEADER_BITS-1:0] sh_q, sh_d;
  logic [6:0]             rx_sh_q, rx_sh_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic [LENGTH_SZ-1:0]   len_q, len_d;
  logic [LENGTH_SZ-1:0]   byte_cnt_q, byte_cnt_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;
  logic                   need_load_q, need_load_d;
  logic                   stall_q, stall_d;
  logic                   cs_q, cs_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   tx_ready_q, tx_ready_d;

  logic sclk, sclk_en, rise_stb, fall_stb;

  // In HOLD the divider runs only long enough to finish the last high phase.
  assign sclk_en = (state_q == HEADER) ||
                   (state_q == PAYLOAD && !stall_q) ||
                   (state_q == HOLD && sclk);

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .en       (sclk_en),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign bus.sclk          = sclk;
  assign bus.mosi          = sh_q[HEADER_BITS-1];
  assign bus.cs            = cs_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rx_byte       = rx_byte_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.tx_data_ready = tx_ready_q;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    rx_sh_d     = rx_sh_q;
    rx_byte_d   = rx_byte_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    need_load_d = need_load_q;
    stall_d     = stall_q;
    cs_d        = cs_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rx_valid_d  = 1'b0;
    tx_ready_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = HEADER;
          sh_d        = {bus.tx_type, bus.tx_length, bus.tx_prefix};
          len_d       = bus.tx_length;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          hold_cnt_d  = '0;
          need_load_d = 1'b0;
          stall_d     = 1'b0;
          cs_d        = 1'b0;
          busy_d      = 1'b1;
        end
      end
      HEADER: begin
        if (rise_stb) begin
          if (bit_cnt_q == BC_W'(HEADER_BITS - 1)) begin
            bit_cnt_d = '0;
            if (len_q != '0) begin
              state_d     = PAYLOAD;
              need_load_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (fall_stb) begin
          sh_d = sh_q << 1;
        end
      end
      PAYLOAD: begin
        // Byte boundary: load on the falling edge, or park with sclk low
        // until the host offers the next byte.
        if (stall_q || (fall_stb && need_load_q)) begin
          if (bus.tx_data_valid) begin
            sh_d        = {bus.tx_data, {(HEADER_BITS-8){1'b0}}};
            tx_ready_d  = 1'b1;
            need_load_d = 1'b0;
            stall_d     = 1'b0;
          end else begin
            stall_d = 1'b1;
          end
        end else if (fall_stb) begin
          sh_d = sh_q << 1;
        end else if (rise_stb) begin
          rx_sh_d = {rx_sh_q[5:0], bus.miso};
          if (bit_cnt_q[2:0] == 3'd7) begin
            bit_cnt_d  = '0;
            rx_byte_d  = {rx_sh_q, bus.miso};
            rx_valid_d = 1'b1;
            if (byte_cnt_q == len_q - LENGTH_SZ'(1)) begin
              state_d = HOLD;
            end else begin
              byte_cnt_d  = byte_cnt_q + 1'b1;
              need_load_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (!sclk) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (hold_cnt_q == HC_W'(CLK_DIV - 1)) begin
            cs_d = 1'b1;
            sh_d = '0;
          end
          if (hold_cnt_q == HC_W'(CLK_DIV + CS_GAP - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      rx_sh_q     <= '0;
      rx_byte_q   <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      need_load_q <= 1'b0;
      stall_q     <= 1'b0;
      cs_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      rx_sh_q     <= rx_sh_d;
      rx_byte_q   <= rx_byte_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      need_load_q <= need_load_d;
      stall_q     <= stall_d;
      cs_q        <= cs_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rx_valid_q  <= rx_valid_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

endmodule
